// File: rtl/Purple_Jade.sv
// Purple_Jade shared package: machine-wide widths used by the front end.
package Purple_Jade;

  // Native machine word size.
  localparam int WORD_SIZE_P = 32;

  // Width of one decoded instruction as handed from decode to rename.
  localparam int DECODED_INSTRUCTION_WIDTH = WORD_SIZE_P;

endpackage : Purple_Jade

// File: rtl/decode_queue_if.sv
// decode_queue_if: decoder -> queue -> rename handshake bundle.
// master = the side driving decoder/backend inputs, slave = the queue itself.
interface decode_queue_if
  import Purple_Jade::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DECODED_INSTRUCTION_WIDTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             dec_v;
  logic [WIDTH-1:0] dec_instr;
  logic             dec_ready;
  logic [WIDTH-1:0] decoded;
  logic             decoded_v;
  logic             rename_ready;
  logic             mispredict;
  logic [CW-1:0]    count;

  modport master (
    output dec_v, dec_instr, rename_ready, mispredict,
    input  dec_ready, decoded, decoded_v, count
  );

  modport slave (
    input  dec_v, dec_instr, rename_ready, mispredict,
    output dec_ready, decoded, decoded_v, count
  );

endinterface : decode_queue_if

// File: rtl/decode_queue.sv
// decode_queue: FIFO of decoded instructions between decode and rename.
// Flop-array storage, wrap-around head/tail pointers, separate occupancy
// counter. A backend mispredict or reset empties the queue in one cycle.
// Optional feature macro: DECODE_QUEUE_BYPASS_EN -- when defined, an entry
// arriving at an empty queue is presented to rename in the same cycle.
module decode_queue
  import Purple_Jade::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DECODED_INSTRUCTION_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       dec_v_i,
  input  logic [WIDTH-1:0]           dec_instr_i,
  output logic                       dec_ready_o,
  output logic [WIDTH-1:0]           decoded_o,
  output logic                       decoded_v_o,
  input  logic                       rename_ready_i,
  input  logic                       mispredict_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_stored_v;
  logic w_bypass_v;
  logic w_push;
  logic w_pop;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_COUNT);
  // A stored head entry is offered unless a flush or reset is in progress.
  assign w_stored_v = !w_empty & !mispredict_i & !reset_i;

`ifdef DECODE_QUEUE_BYPASS_EN
  // Empty queue: the decoder's entry goes straight through to rename.
  assign w_bypass_v = w_empty & dec_v_i & !mispredict_i & !reset_i;
  assign decoded_o  = w_empty ? dec_instr_i : r_mem[r_head];
`else
  // Registered-only path: nothing from the decoder reaches the outputs combinationally.
  assign w_bypass_v = 1'b0;
  assign decoded_o  = r_mem[r_head];
`endif

  assign decoded_v_o = w_stored_v | w_bypass_v;
  assign dec_ready_o = !w_full & !reset_i;
  assign count_o     = reset_i ? '0 : r_count;

  // A bypassed entry that rename takes this cycle is consumed and never stored.
  assign w_push = dec_v_i & dec_ready_o & !mispredict_i & !(w_bypass_v & rename_ready_i);
  // Only stored entries advance the head.
  assign w_pop  = w_stored_v & rename_ready_i;

  // Entry storage: write at the tail on every accepted push (no reset needed).
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_tail] <= dec_instr_i;
    end
  end

  // Pointers and occupancy: cleared by reset or flush, otherwise advanced by push/pop.
  always_ff @(posedge clk_i) begin
    if (reset_i || mispredict_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : decode_queue

// File: tb/tb_decode_queue.sv
// tb_decode_queue: self-checking bench for decode_queue with a queue-based
// reference model. Directed scenarios plus a randomized run.
// Honours DECODE_QUEUE_BYPASS_EN the same way as the design.
module tb_decode_queue;
  import Purple_Jade::*;

  localparam int DEPTH = 4;
  localparam int W     = DECODED_INSTRUCTION_WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef DECODE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [W-1:0] mq [$];

  always #5 clk = ~clk;

  decode_queue_if #(.DEPTH(DEPTH), .WIDTH(W)) dq_if ();

  decode_queue #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .dec_v_i        (dq_if.dec_v),
    .dec_instr_i    (dq_if.dec_instr),
    .dec_ready_o    (dq_if.dec_ready),
    .decoded_o      (dq_if.decoded),
    .decoded_v_o    (dq_if.decoded_v),
    .rename_ready_i (dq_if.rename_ready),
    .mispredict_i   (dq_if.mispredict),
    .count_o        (dq_if.count)
  );

  // Reference model: advance the expected queue contents by one clock.
  function automatic void model_step();
    bit bt, pop, push;
    if (rst || dq_if.mispredict) begin
      mq.delete();
    end else begin
      bt   = BYP && mq.size() == 0 && dq_if.dec_v && dq_if.rename_ready;
      pop  = mq.size() != 0 && dq_if.rename_ready;
      push = dq_if.dec_v && mq.size() != DEPTH && !bt;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(dq_if.dec_instr);
    end
  endfunction

  // Reference model: expected {valid, ready, count, data} for the current inputs.
  function automatic logic [W+CW+1:0] model_outs();
    logic ev, er;
    logic [CW-1:0] ec;
    logic [W-1:0]  ed;
    ev = !rst && !dq_if.mispredict && (mq.size() != 0 || (BYP && dq_if.dec_v));
    er = !rst && mq.size() != DEPTH;
    ec = rst ? '0 : CW'(mq.size());
    ed = '0;
    if (ev) ed = (mq.size() != 0) ? mq[0] : dq_if.dec_instr;
    return {ev, er, ec, ed};
  endfunction

  function automatic logic [W+CW+1:0] dut_outs();
    return {dq_if.decoded_v, dq_if.dec_ready, dq_if.count,
            dq_if.decoded_v ? dq_if.decoded : {W{1'b0}}};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic rr,
                       input logic mp, input logic r);
    dq_if.dec_v        = v;
    dq_if.dec_instr    = d;
    dq_if.rename_ready = rr;
    dq_if.mispredict   = mp;
    rst                = r;
    #1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (dq_if.dec_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_during got=%b want=0", dq_if.dec_ready); end
    n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL reset_valid_during got=%b want=0", dq_if.decoded_v); end
    n_checks++; if (dq_if.count !== '0) begin n_fail++; $display("FAIL reset_count_during got=%0d want=0", dq_if.count); end
    tick();
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (dq_if.dec_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b want=1", dq_if.dec_ready); end
    n_checks++; if (dq_if.count !== '0) begin n_fail++; $display("FAIL reset_count_after got=%0d want=0", dq_if.count); end
    n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL reset_valid_after got=%b want=0", dq_if.decoded_v); end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4];
    vals = '{W'(32'h11), W'(32'h22), W'(32'h33), W'(32'h44)};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (dq_if.count !== CW'(4)) begin n_fail++; $display("FAIL fill_count got=%0d want=4", dq_if.count); end
    n_checks++; if (dq_if.dec_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready got=%b want=0", dq_if.dec_ready); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({dq_if.decoded_v, dq_if.decoded} !== {1'b1, vals[i]}) begin
        n_fail++; $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, dq_if.decoded_v, dq_if.decoded, vals[i]);
      end
      $display("pop %0d data=%h", i, dq_if.decoded);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (dq_if.count !== '0) begin n_fail++; $display("FAIL drain_count got=%0d want=0", dq_if.count); end
    n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b want=0", dq_if.decoded_v); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] exp_seq [4];
    exp_seq = '{W'(32'hA2), W'(32'hA3), W'(32'hA4), W'(32'h55)};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(32'hA1 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, W'(32'h55), 1'b1, 1'b0, 1'b0);
    n_checks++; if (dq_if.dec_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b want=0", dq_if.dec_ready); end
    n_checks++; if (dq_if.decoded !== W'(32'hA1)) begin n_fail++; $display("FAIL full_head got=%h want=a1", dq_if.decoded); end
    tick();
    drive(1'b1, W'(32'h55), 1'b0, 1'b0, 1'b0);
    n_checks++; if (dq_if.count !== CW'(3)) begin n_fail++; $display("FAIL full_pushpop_count got=%0d want=3", dq_if.count); end
    n_checks++; if (dq_if.dec_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after got=%b want=1", dq_if.dec_ready); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (dq_if.count !== CW'(4)) begin n_fail++; $display("FAIL held_push_count got=%0d want=4", dq_if.count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({dq_if.decoded_v, dq_if.decoded} !== {1'b1, exp_seq[i]}) begin
        n_fail++; $display("FAIL full_drain_%0d got v=%b d=%h want v=1 d=%h", i, dq_if.decoded_v, dq_if.decoded, exp_seq[i]);
      end
      tick();
    end
    $display("test_full_push_pop done");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sent [$];
    int lat;
    bit exp_v;
    lat = BYP ? 0 : 1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      if (cyc < 10) begin
        sent.push_back(d);
        drive(1'b1, d, 1'b1, 1'b0, 1'b0);
      end else begin
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      exp_v = (cyc >= lat) && (cyc < lat + 10);
      n_checks++;
      if (dq_if.decoded_v !== exp_v) begin
        n_fail++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", cyc, dq_if.decoded_v, exp_v);
      end else if (exp_v) begin
        n_checks++;
        if (dq_if.decoded !== sent[cyc - lat]) begin
          n_fail++; $display("FAIL b2b_data cyc=%0d got=%h want=%h", cyc, dq_if.decoded, sent[cyc - lat]);
        end
      end
      $display("b2b cyc=%0d v=%b d=%h cnt=%0d", cyc, dq_if.decoded_v, dq_if.decoded, dq_if.count);
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(32'hB1 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, W'(32'h66), 1'b1, 1'b1, 1'b0);
    n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL flush_valid_during got=%b want=0", dq_if.decoded_v); end
    tick();
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_checks++; if (dq_if.count !== '0) begin n_fail++; $display("FAIL flush_count got=%0d want=0", dq_if.count); end
    n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b want=0", dq_if.decoded_v); end
    tick();
    n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL flush_leak got v=%b d=%h want v=0", dq_if.decoded_v, dq_if.decoded); end
    $display("test_flush done");
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, W'(32'hC1 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (dq_if.count !== CW'(2)) begin n_fail++; $display("FAIL midrst_pre_count got=%0d want=2", dq_if.count); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (dq_if.dec_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_during got=%b want=0", dq_if.dec_ready); end
    n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_during got=%b want=0", dq_if.decoded_v); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (dq_if.count !== '0) begin n_fail++; $display("FAIL midrst_count got=%0d want=0", dq_if.count); end
    n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got=%b want=0", dq_if.decoded_v); end
    n_checks++; if (dq_if.dec_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b want=1", dq_if.dec_ready); end
    $display("test_reset_midop done");
  endtask

  task automatic test_bypass();
    drive(1'b1, W'(32'h77), 1'b1, 1'b0, 1'b0);
    if (BYP) begin
      n_checks++;
      if ({dq_if.decoded_v, dq_if.decoded} !== {1'b1, W'(32'h77)}) begin
        n_fail++; $display("FAIL bypass_same_cycle got v=%b d=%h want v=1 d=77", dq_if.decoded_v, dq_if.decoded);
      end
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++; if (dq_if.count !== '0) begin n_fail++; $display("FAIL bypass_count got=%0d want=0", dq_if.count); end
      n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL bypass_after_valid got=%b want=0", dq_if.decoded_v); end
    end else begin
      n_checks++; if (dq_if.decoded_v !== 1'b0) begin n_fail++; $display("FAIL nobypass_same_cycle got=%b want=0", dq_if.decoded_v); end
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({dq_if.decoded_v, dq_if.decoded, dq_if.count} !== {1'b1, W'(32'h77), CW'(1)}) begin
        n_fail++; $display("FAIL nobypass_next got v=%b d=%h cnt=%0d want v=1 d=77 cnt=1", dq_if.decoded_v, dq_if.decoded, dq_if.count);
      end
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (dq_if.count !== '0) begin n_fail++; $display("FAIL nobypass_count got=%0d want=0", dq_if.count); end
    end
    $display("test_bypass done (bypass=%0b)", BYP);
  endtask

  task automatic test_random();
    logic [W+CW+1:0] exp_o, got_o;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic v, rr, mp, r;
      v  = ($urandom_range(0, 3) != 0);
      rr = ((cyc / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      mp = ($urandom_range(0, 24) == 0);
      r  = ($urandom_range(0, 59) == 0);
      drive(v, W'($urandom), rr, mp, r);
      exp_o = model_outs();
      got_o = dut_outs();
      n_checks++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL random cyc=%0d got v=%b rdy=%b cnt=%0d d=%h want v=%b rdy=%b cnt=%0d d=%h",
                 cyc, got_o[W+CW+1], got_o[W+CW], got_o[W+CW-1:W], got_o[W-1:0],
                 exp_o[W+CW+1], exp_o[W+CW], exp_o[W+CW-1:W], exp_o[W-1:0]);
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_decode_queue
